wr_stream_adapter: RTL and testbench

Write-side front end for the asynchronous FIFO. It converts a valid/ready source stream into the `wr_en`/`wr_data` strobe consumed by the write-pointer/full stage, using a two-entry skid buffer so that `s_ready` is fully registered. It also computes a registered write-domain fill level and an `almost_full` flag from the write pointer and the synchronized read pointer. The block lives entirely in the write clock domain.

---
 rtl/wr_stream_adapter.sv | 153 +++++++++++++++
 tb/tb_wr_stream_adapter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_stream_adapter.sv
// -----------------------------------------------------------------------------
// wr_stream_adapter
//
// Write-side front end of the asynchronous FIFO, entirely in the write clock
// domain. It turns a valid/ready source stream into the wr_en/wr_data strobe
// for the write-pointer/full stage. A two-entry skid buffer keeps s_ready a
// pure register output. The block also reports a registered fill level and an
// almost_full flag, both derived from the Gray write pointer and the
// synchronized Gray read pointer.
//
// Ports
//   wr_clk         in   write clock
//   wr_rst_n       in   asynchronous active-low reset
//   s_valid        in   source word valid
//   s_data         in   source word            [DATA_WIDTH]
//   s_ready        out  adapter can accept a word (registered)
//   wr_en          out  write request to the pointer/full stage
//   wr_data        out  word for the FIFO memory write port [DATA_WIDTH]
//   full           in   registered full flag from the pointer/full stage
//   wr_ptr         in   Gray write pointer     [ADDR_WIDTH+1]
//   rd_sync_to_wr  in   Gray read pointer, synchronized to wr_clk [ADDR_WIDTH+1]
//   wr_level       out  registered occupancy seen from the write side [ADDR_WIDTH+1]
//   almost_full    out  registered (wr_level >= AFULL_THRESH)
// -----------------------------------------------------------------------------
module wr_stream_adapter #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = 60
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  full,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic [ADDR_WIDTH:0]   rd_sync_to_wr,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  almost_full
);

    localparam int               PW        = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]    AFULL_LVL = PW'(AFULL_THRESH);

    // -------------------------------------------------------------------------
    // Skid buffer state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_valid;
    logic                  r_s_ready;

    logic                  w_s_hs;
    logic                  w_out_load;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic                  w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] w_skid_data_nxt;
    logic                  w_skid_valid_nxt;

    assign wr_en      = r_out_valid & ~full;
    assign wr_data    = r_out_data;
    assign s_ready    = r_s_ready;

    assign w_s_hs     = s_valid & r_s_ready;
    // The out register may take a new word when it is empty or is being
    // consumed by the FIFO on this edge.
    assign w_out_load = ~r_out_valid | wr_en;

    // NOTE: every output of this block is given a hold value before the
    // branches, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_out_data_nxt   = r_out_data;
        w_skid_data_nxt  = r_skid_data;
        w_skid_valid_nxt = r_skid_valid;
        w_out_valid_nxt  = w_out_load ? (r_skid_valid | w_s_hs) : r_out_valid;

        if (r_skid_valid && w_out_load) begin
            // Skid word is older than anything on s_data, so it goes first.
            // No handshake is possible here because s_ready is low.
            w_out_data_nxt   = r_skid_data;
            w_skid_valid_nxt = 1'b0;
        end else if (w_s_hs && w_out_load) begin
            w_out_data_nxt   = s_data;
        end else if (w_s_hs) begin
            // out is stalled by full: park the word in the skid register.
            w_skid_data_nxt  = s_data;
            w_skid_valid_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // The data registers are reset as well, so wr_data is a known 0 after
    // reset rather than whatever the flops powered up with.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b1;
        end else begin
            r_out_data   <= w_out_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Registered copy of "skid will be empty after this edge".
            r_s_ready    <= ~w_skid_valid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Fill level and almost_full
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b         = '0;
        b[PW-1]   = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] w_wr_bin;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_level_nxt;
    logic [PW-1:0] r_wr_level;
    logic          r_almost_full;

    assign w_wr_bin    = gray2bin(wr_ptr);
    assign w_rd_bin    = gray2bin(rd_sync_to_wr);
    // Pointers carry one extra wrap bit, so the modulo-2^PW difference is the
    // true occupancy (0..2^ADDR_WIDTH) even after either pointer wraps.
    assign w_level_nxt = w_wr_bin - w_rd_bin;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_wr_level    <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_level    <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= AFULL_LVL);
        end
    end

    assign wr_level    = r_wr_level;
    assign almost_full = r_almost_full;

endmodule

// File: tb/tb_wr_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_wr_stream_adapter
//
// Directed and randomized stimulus for wr_stream_adapter. The reference model
// is a queue of words accepted by the adapter but not yet written to the FIFO:
// s_ready is expected while fewer than two words are held, wr_en whenever a
// word is held and full is low, and wr_data must be the oldest held word.
// Levels are chosen in binary by the bench and driven as Gray codes.
// -----------------------------------------------------------------------------
module tb_wr_stream_adapter;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int TH = 60;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_sync_to_wr;
    logic [AW:0]   wr_level;
    logic          almost_full;

    wr_stream_adapter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .AFULL_THRESH (TH)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .wr_ptr        (wr_ptr),
        .rd_sync_to_wr (rd_sync_to_wr),
        .wr_level      (wr_level),
        .almost_full   (almost_full)
    );

    always #5 wr_clk = ~wr_clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q[$];        // accepted, not yet written
    int            exp_level;   // registered level expected now
    int            drv_level;   // level implied by the pointers being driven
    int            wren_seen;   // observed wr_en cycles
    int            hs_seen;     // observed handshakes

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive pointers from binary values; level is plain modular arithmetic.
    task automatic set_ptrs(input int wb, input int rb);
        wr_ptr        = to_gray(AW'(0) + (AW+1)'(wb));
        rd_sync_to_wr = to_gray(AW'(0) + (AW+1)'(rb));
        drv_level     = (wb - rb) & ((1 << (AW + 1)) - 1);
    endtask

    task automatic set_level(input int lvl);
        int wb;
        wb = int'($urandom_range(0, (1 << (AW + 1)) - 1));
        set_ptrs(wb, (wb - lvl) & ((1 << (AW + 1)) - 1));
    endtask

    // One clock: drive inputs, compare before the edge, update the model.
    // Entered and left just after a rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic f);
        logic exp_ready;
        logic exp_wren;
        s_valid = v;
        s_data  = d;
        full    = f;
        @(negedge wr_clk);
        exp_ready = (q.size() < 2);
        exp_wren  = (q.size() > 0) && !f;
        check("s_ready", 32'(s_ready), 32'(exp_ready));
        check("wr_en",   32'(wr_en),   32'(exp_wren));
        if (exp_wren) check("wr_data", 32'(wr_data), 32'(q[0]));
        check("wr_level",    32'(wr_level),    32'(exp_level));
        check("almost_full", 32'(almost_full), 32'(exp_level >= TH));
        if (wr_en === 1'b1) wren_seen++;
        if (v && s_ready === 1'b1) hs_seen++;
        @(posedge wr_clk);
        if (exp_wren) void'(q.pop_front());
        if (v && exp_ready) q.push_back(d);
        exp_level = drv_level;
        #1;
    endtask

    initial begin
        wr_rst_n  = 1'b0;
        s_valid   = 1'b1;
        s_data    = 8'hA5;
        full      = 1'b0;
        exp_level = 0;
        wren_seen = 0;
        hs_seen   = 0;
        set_level(40);

        // Reset held for three cycles with s_valid high and a nonzero level.
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            check("rst_s_ready",     32'(s_ready),     32'd1);
            check("rst_wr_en",       32'(wr_en),       32'd0);
            check("rst_wr_level",    32'(wr_level),    32'd0);
            check("rst_almost_full", 32'(almost_full), 32'd0);
            @(posedge wr_clk);
        end
        #1 wr_rst_n = 1'b1;

        // First word after release, then back-to-back streaming 0x00..0x3F.
        set_ptrs(0, 0);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        wren_seen = 0;
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("stream_wren_cycles", 32'(wren_seen), 32'd64);

        // Backpressure: full rises mid-stream, at most two more handshakes.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        hs_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b1);
        check("bp_hs_le2", 32'(hs_seen <= 2), 32'd1);
        check("bp_s_ready_low", 32'(s_ready), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Level with pointer wrap.
        set_ptrs(8'h45, 8'h09);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("lvl_60", 32'(wr_level), 32'd60);
        set_ptrs(8'h02, 8'h7F);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("lvl_wrap_3", 32'(wr_level), 32'd3);

        // Threshold edge 59 -> 60 -> 59; each step checks the pre-edge value.
        set_level(59); step(1'b0, 8'h00, 1'b0);
        set_level(60); step(1'b0, 8'h00, 1'b0);
        set_level(59); step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Randomized traffic, backpressure and levels.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) set_level(int'($urandom_range(0, 1 << AW)));
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

        // Reset mid-operation with both registers occupied and full high.
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b1);
        step(1'b1, 8'hE3, 1'b1);
        step(1'b1, 8'hE4, 1'b1);
        check("pre_rst_s_ready", 32'(s_ready), 32'd0);
        full = 1'b0;
        #2 wr_rst_n = 1'b0;
        #1;
        check("async_rst_wr_en",   32'(wr_en),   32'd0);
        check("async_rst_s_ready", 32'(s_ready), 32'd1);
        check("async_rst_level",   32'(wr_level), 32'd0);
        q.delete();
        exp_level = 0;
        @(posedge wr_clk);
        #1 wr_rst_n = 1'b1;
        wren_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check("post_rst_no_stale", 32'(wren_seen), 32'd0);
        step(1'b1, 8'h7E, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
